// File: rtl/regfile_ctrl_pkg.sv
// Purpose : shared constants and types for the register-file write scheduler.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: XLEN/NREG/REG_AW sizing, requester IDs, write-request struct.
package regfile_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  // Requester indices into the arbiter request/grant vectors.
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose : two-input round-robin arbiter; prio flips to the loser after every grant.
// Latency : grant is combinational from requests and the registered prio.
// Backpr. : a non-granted requester simply waits; grants are forced low during reset.
// Ports   : clock, reset_n (sync, active-low), i_req[1:0] requests, o_gnt[1:0] one-hot grant.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic       r_prio;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (reset_n) begin
      if (i_req[REQ_ALU] && i_req[REQ_MEM]) begin
        w_gnt[r_prio] = 1'b1;
      end else begin
        w_gnt = i_req;
      end
    end
  end

  // After a grant the other requester becomes preferred: granting ALU
  // makes MEM (1) the priority, granting MEM makes ALU (0) the priority.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_prio <= 1'b0;
    end else if (|w_gnt) begin
      r_prio <= w_gnt[REQ_ALU];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_write_sched.sv
// Purpose : shares the single register-file write port between ALU and load
//           writeback, and keeps a pending-write scoreboard for RAW hazard detection.
// Latency : accept in cycle N -> RegWrite/RD/WriteData registered, visible in N+1.
// Backpr. : valid/ready per requester; the loser holds its request, waits at most 1 cycle.
// Ports   : alu_*/mem_* write requests, rsv_* issue-stage reservation, Read1/Read2
//           snooped read addresses -> hazard1/hazard2, RegWrite/RD/WriteData write
//           port, pending scoreboard.
module regfile_write_sched #(
  parameter int XLEN = regfile_ctrl_pkg::XLEN,
  parameter int NREG = regfile_ctrl_pkg::NREG
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            rsv_valid,
  input  logic [4:0]      rsv_rd,
  input  logic [4:0]      Read1,
  input  logic [4:0]      Read2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            RegWrite,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] WriteData,
  output logic [NREG-1:0] pending
);
  import regfile_ctrl_pkg::*;

  logic [1:0]      w_gnt;
  logic            w_acc;
  wr_req_t         w_sel;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  logic            r_regwrite;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic [NREG-1:0] r_pending;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .i_req   ({mem_valid, alu_valid}),
    .o_gnt   (w_gnt)
  );

  assign alu_ready = w_gnt[REQ_ALU];
  assign mem_ready = w_gnt[REQ_MEM];
  assign w_acc     = |w_gnt;

  always_comb begin
    w_sel.rd   = alu_rd;
    w_sel.data = alu_data;
    if (w_gnt[REQ_MEM]) begin
      w_sel.rd   = mem_rd;
      w_sel.data = mem_data;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
    end else if (w_acc) begin
      r_regwrite <= (w_sel.rd != '0);
      r_rd       <= w_sel.rd;
      r_wdata    <= w_sel.data;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  // Set sources: issue reservation and newly accepted writes. Clear source:
  // the write being performed this cycle. Set is applied after clear so a
  // same-cycle reservation of the register being written keeps it pending.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rsv_valid)  w_set = w_set | (NREG'(1) << rsv_rd);
    if (w_acc)      w_set = w_set | (NREG'(1) << w_sel.rd);
    if (r_regwrite) w_clr = NREG'(1) << r_rd;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~NREG'(1);
    end
  end

  // Bit 0 is never set, so address 0 reads as hazard-free.
  assign hazard1   = r_pending[Read1];
  assign hazard2   = r_pending[Read2];

  assign RegWrite  = r_regwrite;
  assign RD        = r_rd;
  assign WriteData = r_wdata;
  assign pending   = r_pending;

endmodule

// File: tb/tb_regfile_write_sched.sv
module tb_regfile_write_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid, rsv_valid;
  logic [4:0]  alu_rd, mem_rd, rsv_rd, Read1, Read2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, hazard1, hazard2, RegWrite;
  logic [4:0]  RD;
  logic [31:0] WriteData;
  logic [31:0] pending;

  int vectors = 0;
  int miscompares = 0;

  regfile_write_sched #(.XLEN(32), .NREG(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .Read1     (Read1),
    .Read2     (Read2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .RegWrite  (RegWrite),
    .RD        (RD),
    .WriteData (WriteData),
    .pending   (pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0003;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hBBBB_0004;
    rsv_valid = 1'b0; rsv_rd = 5'd0;
    Read1 = 5'd0; Read2 = 5'd0;

    // Reset held 2 cycles with both valids high.
    tick();
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    check("rst_pending",   pending, 32'd0);
    check("rst_regwrite",  {31'd0, RegWrite}, 32'd0);
    check("rst_rd",        {27'd0, RD}, 32'd0);
    check("rst_wdata",     WriteData, 32'd0);

    // Release: contention ALU rd=3 / MEM rd=4, first grant ALU.
    reset_n = 1'b1;
    #1;
    check("c1_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("c1_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    check("c1_regwrite", {31'd0, RegWrite}, 32'd1);
    check("c1_rd",       {27'd0, RD}, 32'd3);
    check("c1_wdata",    WriteData, 32'hAAAA_0003);
    check("c1_pending",  pending, 32'h0000_0008);
    check("c2_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("c2_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    check("c2_rd",       {27'd0, RD}, 32'd4);
    check("c2_wdata",    WriteData, 32'hBBBB_0004);
    check("c2_pending",  pending, 32'h0000_0010);
    check("c3_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    check("c3_rd",       {27'd0, RD}, 32'd3);
    check("c3_pending",  pending, 32'h0000_0008);
    check("c4_mem_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("c4_rd",       {27'd0, RD}, 32'd4);
    check("c4_regwrite", {31'd0, RegWrite}, 32'd1);
    tick();
    check("c_idle_regwrite", {31'd0, RegWrite}, 32'd0);
    check("c_idle_pending",  pending, 32'd0);

    // Single write: ALU rd=5 data=0x1234.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    #1;
    check("sw_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("sw_pending_n", pending, 32'd0);
    tick();
    alu_valid = 1'b0;
    check("sw_regwrite", {31'd0, RegWrite}, 32'd1);
    check("sw_rd",       {27'd0, RD}, 32'd5);
    check("sw_wdata",    WriteData, 32'h0000_1234);
    check("sw_pending",  pending, 32'h0000_0020);
    tick();
    check("sw_regwrite_off", {31'd0, RegWrite}, 32'd0);
    check("sw_pending_clr",  pending, 32'd0);
    check("sw_rd_hold",      {27'd0, RD}, 32'd5);
    check("sw_wdata_hold",   WriteData, 32'h0000_1234);

    // Reservation and hazard on x7.
    rsv_valid = 1'b1; rsv_rd = 5'd7; Read1 = 5'd7; Read2 = 5'd7;
    #1;
    check("rv0_hazard1", {31'd0, hazard1}, 32'd0);
    tick();
    rsv_valid = 1'b0;
    #1;
    check("rv1_hazard1", {31'd0, hazard1}, 32'd1);
    check("rv1_hazard2", {31'd0, hazard2}, 32'd1);
    tick();
    check("rv2_hazard1", {31'd0, hazard1}, 32'd1);
    tick();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_7777;
    #1;
    check("rv3_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("rv3_hazard1",   {31'd0, hazard1}, 32'd1);
    tick();
    mem_valid = 1'b0;
    check("rv4_regwrite", {31'd0, RegWrite}, 32'd1);
    check("rv4_rd",       {27'd0, RD}, 32'd7);
    check("rv4_hazard1",  {31'd0, hazard1}, 32'd1);
    tick();
    check("rv5_hazard1",  {31'd0, hazard1}, 32'd0);
    Read1 = 5'd0; Read2 = 5'd0;

    // Set/clear collision on x9.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
    tick();
    alu_valid = 1'b0;
    rsv_valid = 1'b1; rsv_rd = 5'd9;
    check("col_regwrite", {31'd0, RegWrite}, 32'd1);
    check("col_rd",       {27'd0, RD}, 32'd9);
    tick();
    rsv_valid = 1'b0; Read1 = 5'd9;
    #1;
    check("col_pending", pending, 32'h0000_0200);
    check("col_hazard1", {31'd0, hazard1}, 32'd1);
    // Retire the reservation with a load write to x9.
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0000_0909;
    tick();
    mem_valid = 1'b0;
    tick();
    check("col_retired", pending, 32'd0);
    Read1 = 5'd0;

    // Write to x0: accepted, no register write, no scoreboard bit.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_FFFF; Read2 = 5'd0;
    #1;
    check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("x0_hazard2",   {31'd0, hazard2}, 32'd0);
    tick();
    alu_valid = 1'b0;
    check("x0_regwrite", {31'd0, RegWrite}, 32'd0);
    check("x0_pending",  pending, 32'd0);
    check("x0_hazard2b", {31'd0, hazard2}, 32'd0);

    // Reset mid-operation discards the in-flight write.
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0DE_000C;
    tick();
    alu_valid = 1'b0;
    check("mr_regwrite", {31'd0, RegWrite}, 32'd1);
    check("mr_pending",  pending, 32'h0000_1000);
    reset_n = 1'b0; alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    check("mr_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("mr_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    check("mr_regwrite_rst", {31'd0, RegWrite}, 32'd0);
    check("mr_pending_rst",  pending, 32'd0);
    check("mr_rd_rst",       {27'd0, RD}, 32'd0);
    check("mr_wdata_rst",    WriteData, 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
